line_buffer_apb_if: RTL and testbench

APB3 slave front-end for the line buffer configuration space. Decodes APB transfers from the system bus into the per-register select, write strobe and write data consumed by the line buffer register block. Returns read data from that block's `*_ff` outputs. Also generates PREADY wait states and PSLVERR.

---
 rtl/line_buffer_apb_if.sv | 188 ++++++++++++++++++
 tb/tb_line_buffer_apb_if.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_apb_if.sv
// APB3 slave front-end for the line buffer register block: decodes transfers into
// one-hot selects and a write strobe, returns zero-extended read-back data.
module line_buffer_apb_if #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              apbif_wr,
   output logic [31:0]       apbif_wdata,
   output logic              ctrl_ff_sel,
   output logic              real_depth_ff_sel,
   output logic              line_wr_ff_sel,
   output logic              ram_base_ff_sel,
   output logic              ram_base_offset_ff_sel,
   output logic              actived_chnl_ff_sel,
   output logic              actived_chnl_bits_ff_sel,
   output logic              inactived_chnl_bits_ff_sel,
   output logic              ro_test_ff_sel,
   input  logic [5:0]        ctrl_ff,
   input  logic [15:0]       real_depth_ff,
   input  logic [15:0]       line_wr_ff,
   input  logic [31:0]       ram_base_ff,
   input  logic [31:0]       ram_base_offset_ff,
   input  logic [15:0]       actived_chnl_ff,
   input  logic [31:0]       actived_chnl_bits_ff,
   input  logic [15:0]       inactived_chnl_bits_ff,
   input  logic [23:0]       ro_test_ff
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic        r_hit;
   logic [3:0]  r_idx;
   logic [8:0]  r_sel;
   logic        r_wr;
   logic        r_pready;
   logic        r_pslverr;
   logic [31:0] r_prdata;
   logic [31:0] r_wdata;

   logic        w_setup;
   logic        w_hit;
   logic [8:0]  w_dec_sel;
   logic [31:0] w_rdata;

   assign w_setup = psel & ~penable;

   // Address decode: word-aligned 0x00..0x20 with all upper bits clear
   always_comb begin
      w_dec_sel = 9'h000;
      w_hit     = (paddr[1:0] == 2'b00) && (paddr <= ADDR_W'(32'h20));
      for (int i = 0; i < 9; i++) begin
         w_dec_sel[i] = w_hit && (paddr[5:2] == 4'(i));
      end
   end

   // Read-back mux, zero-extending each register to the bus width
   always_comb begin
      w_rdata = 32'h0000_0000;
      case (r_idx)
         4'd0:    w_rdata = {26'h0, ctrl_ff};
         4'd1:    w_rdata = {16'h0, real_depth_ff};
         4'd2:    w_rdata = {16'h0, line_wr_ff};
         4'd3:    w_rdata = ram_base_ff;
         4'd4:    w_rdata = ram_base_offset_ff;
         4'd5:    w_rdata = {16'h0, actived_chnl_ff};
         4'd6:    w_rdata = actived_chnl_bits_ff;
         4'd7:    w_rdata = {16'h0, inactived_chnl_bits_ff};
         4'd8:    w_rdata = {8'h0, ro_test_ff};
         default: w_rdata = 32'h0000_0000;
      endcase
   end

   // State register
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; penable in IDLE and psel in RESP are deliberately ignored
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_setup) w_next = ST_ACCESS;
            else         w_next = ST_IDLE;
         end
         ST_ACCESS: begin
            if (!psel)              w_next = ST_IDLE;
            else if (r_cnt == 4'd0) w_next = ST_RESP;
            else                    w_next = ST_ACCESS;
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Transfer capture, wait counter and registered response outputs
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_cnt     <= 4'd0;
         r_write   <= 1'b0;
         r_hit     <= 1'b0;
         r_idx     <= 4'd0;
         r_sel     <= 9'h000;
         r_wr      <= 1'b0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= 32'h0000_0000;
         r_wdata   <= 32'h0000_0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_setup) begin
                  r_cnt   <= 4'(WAIT_CYCLES);
                  r_write <= pwrite;
                  r_hit   <= w_hit;
                  r_idx   <= paddr[5:2];
                  r_sel   <= w_dec_sel;
                  r_wdata <= pwdata;
               end
            end
            ST_ACCESS: begin
               if (!psel) begin
                  r_sel <= 9'h000;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_pready  <= 1'b1;
                  r_wr      <= r_write & r_hit;
                  r_pslverr <= ~r_hit;
                  r_prdata  <= (r_hit && !r_write) ? w_rdata : 32'h0000_0000;
               end
            end
            ST_RESP: begin
               r_pready  <= 1'b0;
               r_wr      <= 1'b0;
               r_pslverr <= 1'b0;
               r_prdata  <= 32'h0000_0000;
               r_sel     <= 9'h000;
            end
            default: begin
               r_pready  <= 1'b0;
               r_wr      <= 1'b0;
               r_pslverr <= 1'b0;
               r_prdata  <= 32'h0000_0000;
               r_sel     <= 9'h000;
            end
         endcase
      end
   end

   assign prdata                     = r_prdata;
   assign pready                     = r_pready;
   assign pslverr                    = r_pslverr;
   assign apbif_wr                   = r_wr;
   assign apbif_wdata                = r_wdata;
   assign ctrl_ff_sel                = r_sel[0];
   assign real_depth_ff_sel          = r_sel[1];
   assign line_wr_ff_sel             = r_sel[2];
   assign ram_base_ff_sel            = r_sel[3];
   assign ram_base_offset_ff_sel     = r_sel[4];
   assign actived_chnl_ff_sel        = r_sel[5];
   assign actived_chnl_bits_ff_sel   = r_sel[6];
   assign inactived_chnl_bits_ff_sel = r_sel[7];
   assign ro_test_ff_sel             = r_sel[8];

endmodule

// File: tb/tb_line_buffer_apb_if.sv
// Bench for line_buffer_apb_if: two instances (0 and 3 wait states), a cycle-level
// transfer model compared every cycle, plus directed transfers with literal expectations.
module tb_line_buffer_apb_if;

   logic              pclk;
   logic              preset  [2];
   logic              psel    [2];
   logic              penable [2];
   logic              pwrite  [2];
   logic [11:0]       paddr   [2];
   logic [31:0]       pwdata  [2];
   logic [31:0]       prdata  [2];
   logic              pready  [2];
   logic              pslverr [2];
   logic              wr_o    [2];
   logic [31:0]       wdata_o [2];
   logic [1:0][8:0]   sel;
   bit   [31:0]       rf      [2][8];
   logic [23:0]       ro_val  [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nstr  [2];

   // model state
   bit          m_busy  [2];
   int          m_t     [2];
   logic [11:0] m_addr  [2];
   bit          m_wr    [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_rd    [2];
   bit   [31:0] mrf     [2][8];

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   line_buffer_apb_if #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
      .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
      .pready(pready[0]), .pslverr(pslverr[0]), .apbif_wr(wr_o[0]), .apbif_wdata(wdata_o[0]),
      .ctrl_ff_sel(sel[0][0]), .real_depth_ff_sel(sel[0][1]), .line_wr_ff_sel(sel[0][2]),
      .ram_base_ff_sel(sel[0][3]), .ram_base_offset_ff_sel(sel[0][4]),
      .actived_chnl_ff_sel(sel[0][5]), .actived_chnl_bits_ff_sel(sel[0][6]),
      .inactived_chnl_bits_ff_sel(sel[0][7]), .ro_test_ff_sel(sel[0][8]),
      .ctrl_ff(rf[0][0][5:0]), .real_depth_ff(rf[0][1][15:0]), .line_wr_ff(rf[0][2][15:0]),
      .ram_base_ff(rf[0][3]), .ram_base_offset_ff(rf[0][4]), .actived_chnl_ff(rf[0][5][15:0]),
      .actived_chnl_bits_ff(rf[0][6]), .inactived_chnl_bits_ff(rf[0][7][15:0]),
      .ro_test_ff(ro_val[0])
   );

   line_buffer_apb_if #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
      .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
      .pready(pready[1]), .pslverr(pslverr[1]), .apbif_wr(wr_o[1]), .apbif_wdata(wdata_o[1]),
      .ctrl_ff_sel(sel[1][0]), .real_depth_ff_sel(sel[1][1]), .line_wr_ff_sel(sel[1][2]),
      .ram_base_ff_sel(sel[1][3]), .ram_base_offset_ff_sel(sel[1][4]),
      .actived_chnl_ff_sel(sel[1][5]), .actived_chnl_bits_ff_sel(sel[1][6]),
      .inactived_chnl_bits_ff_sel(sel[1][7]), .ro_test_ff_sel(sel[1][8]),
      .ctrl_ff(rf[1][0][5:0]), .real_depth_ff(rf[1][1][15:0]), .line_wr_ff(rf[1][2][15:0]),
      .ram_base_ff(rf[1][3]), .ram_base_offset_ff(rf[1][4]), .actived_chnl_ff(rf[1][5][15:0]),
      .actived_chnl_bits_ff(rf[1][6]), .inactived_chnl_bits_ff(rf[1][7][15:0]),
      .ro_test_ff(ro_val[1])
   );

   function automatic logic [31:0] mask_of(int i);
      case (i)
         0:             return 32'h0000_003F;
         1, 2, 5, 7:    return 32'h0000_FFFF;
         3, 4, 6:       return 32'hFFFF_FFFF;
         8:             return 32'h00FF_FFFF;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   function automatic bit m_hit(logic [11:0] a);
      return (a[1:0] == 2'b00) && (a <= 12'h020);
   endfunction

   function automatic logic [31:0] read_val(int k, logic [11:0] a);
      int ix;
      ix = int'(a >> 2);
      if (!m_hit(a)) return 32'h0000_0000;
      if (ix < 8) return mrf[k][ix];
      return {8'h00, ro_val[k]};
   endfunction

   // register block the DUT writes into
   always @(posedge pclk) begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++)
            if (wr_o[k] === 1'b1 && sel[k][i] === 1'b1)
               rf[k][i] <= wdata_o[k] & mask_of(i);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // transfer-level model: t counts cycles since setup, response when t reaches WAIT+2
   function automatic void model_step(int k);
      int wc;
      int ix;
      wc = (k == 0) ? 0 : 3;
      if (preset[k]) begin
         m_busy[k] = 1'b0; m_t[k] = 0; m_wdata[k] = 32'h0;
      end else if (!m_busy[k]) begin
         if (psel[k] && !penable[k]) begin
            m_busy[k] = 1'b1; m_t[k] = 1; m_addr[k] = paddr[k];
            m_wr[k] = pwrite[k]; m_wdata[k] = pwdata[k];
         end
      end else if (m_t[k] == wc + 2) begin
         ix = int'(m_addr[k] >> 2);
         if (m_wr[k] && m_hit(m_addr[k]) && ix < 8) mrf[k][ix] = m_wdata[k] & mask_of(ix);
         m_busy[k] = 1'b0;
      end else if (!psel[k]) begin
         m_busy[k] = 1'b0;
      end else begin
         m_t[k]++;
         if (m_t[k] == wc + 2) m_rd[k] = read_val(k, m_addr[k]);
      end
   endfunction

   // per-cycle compare against the model
   always @(posedge pclk) begin
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         bit       e_pr, h;
         int       wc;
         logic [8:0] e_sel;
         wc    = (k == 0) ? 0 : 3;
         h     = m_hit(m_addr[k]);
         e_pr  = m_busy[k] && (m_t[k] == wc + 2);
         e_sel = (m_busy[k] && h) ? (9'd1 << (m_addr[k] >> 2)) : 9'h000;
         chk($sformatf("m%0d_pready", k), pready[k], e_pr);
         chk($sformatf("m%0d_pslverr", k), pslverr[k], e_pr && !h);
         chk($sformatf("m%0d_wr", k), wr_o[k], e_pr && m_wr[k] && h);
         chk($sformatf("m%0d_sel", k), sel[k], e_sel);
         chk($sformatf("m%0d_wdata", k), wdata_o[k], m_wdata[k]);
         if (!(e_pr && m_wr[k] && h))
            chk($sformatf("m%0d_prdata", k), prdata[k], (e_pr && !m_wr[k] && h) ? m_rd[k] : 32'h0);
         if (wr_o[k] === 1'b1) nstr[k]++;
      end
   end

   // one APB transfer; starts and ends at a negedge, bus released during the response
   task automatic apb(input int k, input logic [11:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output logic wrs,
                      output logic [8:0] sl, output logic [31:0] wd,
                      output int lat, output int selcnt, output int rcyc);
      bit done;
      done = 1'b0; lat = 0; selcnt = 0; rcyc = 0;
      rd = 32'h0; er = 1'b0; wrs = 1'b0; sl = 9'h000; wd = 32'h0;
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = w; paddr[k] = a; pwdata[k] = d;
      while (!done && lat < 40) begin
         @(posedge pclk); #1;
         lat++;
         if (sel[k] != 9'h000) selcnt++;
         if (pready[k] === 1'b1) begin
            done = 1'b1; rd = prdata[k]; er = pslverr[k]; wrs = wr_o[k];
            sl = sel[k]; wd = wdata_o[k]; rcyc = cyc;
         end
         @(negedge pclk);
         if (!done) penable[k] = 1'b1;
      end
      chk("pready_timeout", {31'h0, done}, 32'h1);
      psel[k] = 1'b0; penable[k] = 1'b0;
      @(negedge pclk);
   endtask

   logic [31:0] rd, wd;
   logic        er, wrs;
   logic [8:0]  sl;
   int          lat, sc, c1, c2;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         preset[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
         paddr[k] = 12'h000; pwdata[k] = 32'h0; nstr[k] = 0;
      end
      ro_val[0] = 24'hA5_1234;
      ro_val[1] = 24'h5A_5A5A;
      repeat (2) @(negedge pclk);
      chk("reset_pready", {31'h0, pready[0]}, 32'h0);
      chk("reset_wdata", wdata_o[0], 32'h0);
      chk("reset_sel", {23'h0, sel[1]}, 32'h0);
      preset[0] = 1'b0; preset[1] = 1'b0;
      @(negedge pclk);

      // write hit, no wait states
      apb(0, 12'h004, 1'b1, 32'h0000_ABCD, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("wr04_lat", lat, 2);
      chk("wr04_err", {31'h0, er}, 32'h0);
      chk("wr04_strobe", {31'h0, wrs}, 32'h1);
      chk("wr04_sel", {23'h0, sl}, 32'h0000_0002);
      chk("wr04_wdata", wd, 32'h0000_ABCD);
      apb(0, 12'h004, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("rd04_data", rd, 32'h0000_ABCD);

      // read hit of the read-only register
      apb(0, 12'h020, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("rd20_data", rd, 32'h00A5_1234);
      chk("rd20_err", {31'h0, er}, 32'h0);
      chk("rd20_nowr", {31'h0, wrs}, 32'h0);

      // error responses
      apb(0, 12'h024, 1'b1, 32'hDEAD_BEEF, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("wr24_err", {31'h0, er}, 32'h1);
      chk("wr24_nowr", {31'h0, wrs}, 32'h0);
      chk("wr24_nosel", sc, 0);
      apb(0, 12'h006, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("rd06_data", rd, 32'h0);
      chk("rd06_err", {31'h0, er}, 32'h1);

      // three wait states
      apb(1, 12'h00C, 1'b1, 32'h1234_5678, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("w3_lat", lat, 5);
      chk("w3_strobe", {31'h0, wrs}, 32'h1);
      chk("w3_sel", {23'h0, sl}, 32'h0000_0008);
      chk("w3_selcycles", sc, 5);

      // back-to-back writes
      apb(0, 12'h000, 1'b1, 32'h0000_0015, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("b2b1_sel", {23'h0, sl}, 32'h0000_0001);
      apb(0, 12'h008, 1'b1, 32'h0000_BEEF, rd, er, wrs, sl, wd, lat, sc, c2);
      chk("b2b2_sel", {23'h0, sl}, 32'h0000_0004);
      chk("b2b_gap", c2 - c1, 3);
      apb(0, 12'h000, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("rd00_data", rd, 32'h0000_0015);
      apb(0, 12'h008, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("rd08_data", rd, 32'h0000_BEEF);

      // penable without a setup phase is ignored
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h014;
      repeat (3) @(negedge pclk);
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge pclk);

      // abort mid-ACCESS on the wait-state instance
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h010; pwdata[1] = 32'h77;
      @(negedge pclk); penable[1] = 1'b1;
      @(negedge pclk); psel[1] = 1'b0; penable[1] = 1'b0;
      repeat (3) @(negedge pclk);
      apb(1, 12'h010, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("abort_rd10", rd, 32'h0);
      chk("abort_lat", lat, 5);

      // reset during ACCESS of a write
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h010; pwdata[0] = 32'h99;
      @(negedge pclk); preset[0] = 1'b1; penable[0] = 1'b1;
      @(posedge pclk); #1;
      chk("rstmid_pready", {31'h0, pready[0]}, 32'h0);
      chk("rstmid_wr", {31'h0, wr_o[0]}, 32'h0);
      chk("rstmid_wdata", wdata_o[0], 32'h0);
      chk("rstmid_sel", {23'h0, sel[0]}, 32'h0);
      @(negedge pclk); preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge pclk);
      apb(0, 12'h010, 1'b0, 32'h0, rd, er, wrs, sl, wd, lat, sc, c1);
      chk("rstmid_rd10", rd, 32'h0);
      chk("rstmid_lat", lat, 2);

      repeat (2) @(negedge pclk);
      chk("strobes_0", nstr[0], 3);
      chk("strobes_1", nstr[1], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
